// File: rtl/lcd_pkg.sv
// Shared opcodes, FSM encodings and command-class type for the LCD framebuffer writer.
package lcd_pkg;
  localparam int LCD_COLS  = 132;
  localparam int LCD_PAGES = 9;

  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;
  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_START  = 8'h40;
  localparam logic [7:0] CMD_DISP   = 8'hAE;
  localparam logic [7:0] CMD_REV    = 8'hA6;
  localparam logic [7:0] CMD_ADC    = 8'hA0;
  localparam logic [7:0] CMD_RMW    = 8'hE0;
  localparam logic [7:0] CMD_END    = 8'hEE;
  localparam logic [7:0] CMD_RESET  = 8'hE2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;

  // At most one bit set; all-zero means the opcode is ignored.
  typedef struct packed {
    logic col_lo;
    logic col_hi;
    logic page;
    logic start;
    logic disp;
    logic rev;
    logic adc;
    logic rmw;
    logic rend;
    logic sreset;
  } cmd_cls_t;
endpackage

// File: rtl/lcd_fb_writer_if.sv
// CPU-side request/response handshake of the LCD framebuffer writer.
interface lcd_fb_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_dc;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (output req_valid, req_write, req_dc, req_data,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_write, req_dc, req_data,
                  output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/lcd_cmd_decode.sv
// Combinational SED1565 opcode classifier: one-hot class plus 6-bit operand.
module lcd_cmd_decode
  import lcd_pkg::*;
(
  input  logic [7:0] cmd,
  output cmd_cls_t   cls,
  output logic [5:0] arg
);
  always_comb begin
    cls        = '0;
    arg        = cmd[5:0];
    cls.col_lo = (cmd[7:4] == CMD_COL_LO[7:4]);
    cls.col_hi = (cmd[7:4] == CMD_COL_HI[7:4]);
    cls.page   = (cmd[7:4] == CMD_PAGE[7:4]);
    cls.start  = (cmd[7:6] == CMD_START[7:6]);
    cls.disp   = (cmd[7:1] == CMD_DISP[7:1]);
    cls.rev    = (cmd[7:1] == CMD_REV[7:1]);
    cls.adc    = (cmd[7:1] == CMD_ADC[7:1]);
    cls.rmw    = (cmd == CMD_RMW);
    cls.rend   = (cmd == CMD_END);
    cls.sreset = (cmd == CMD_RESET);
  end
endmodule

// File: rtl/lcd_fb_writer.sv
// LCD framebuffer write port: command/data decode, page/column counters, dummy-read rule.
// Read-modify-write column hold (0xE0/0xEE) is built only with LCD_RMW_EN defined.
module lcd_fb_writer
  import lcd_pkg::*;
#(
  parameter int COLS  = LCD_COLS,
  parameter int PAGES = LCD_PAGES,
  parameter int AW    = 11
) (
  input  logic              pclk,
  input  logic              reset,
  lcd_fb_writer_if.slave    bus,
  output logic [AW-1:0]     fb_addr,
  output logic              fb_we,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic              disp_on,
  output logic              disp_rev,
  output logic              adc_rev,
  output logic [5:0]        start_line
);
  logic [1:0]  state;
  logic [3:0]  page;
  logic [7:0]  col;
  logic        dummy_pend;
  logic        rd_status, rd_dummy, rd_ff;
  cmd_cls_t    cls;
  logic [5:0]  arg;
  logic        take, pos_ok, col_inc_ok, rmw_on;
  logic [AW-1:0] addr;

  lcd_cmd_decode u_dec (.cmd(bus.req_data), .cls(cls), .arg(arg));

  assign bus.req_ready = (state == IDLE);
  assign take          = bus.req_valid && bus.req_ready;
  assign pos_ok        = (32'(page) < PAGES) && (32'(col) < COLS);
  // An out-of-range column never moves; an in-range one saturates at the last column.
  assign col_inc_ok    = 32'(col) < COLS - 1;
  assign addr          = AW'(page) * AW'(COLS) + AW'(col);

`ifdef LCD_RMW_EN
  logic       rmw;
  logic [7:0] saved_col;
  assign rmw_on = rmw;
`else
  logic unused_rmw_cls;
  assign unused_rmw_cls = cls.rmw | cls.rend;
  assign rmw_on = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      state         <= IDLE;
      page          <= '0;
      col           <= '0;
      dummy_pend    <= 1'b1;
      start_line    <= '0;
      disp_on       <= 1'b0;
      disp_rev      <= 1'b0;
      adc_rev       <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_wdata      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      rd_status     <= 1'b0;
      rd_dummy      <= 1'b0;
      rd_ff         <= 1'b0;
`ifdef LCD_RMW_EN
      rmw           <= 1'b0;
      saved_col     <= '0;
`endif
    end else begin
      fb_we         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (take) begin
          if (bus.req_write && bus.req_dc) begin
            if (pos_ok) begin
              fb_we    <= 1'b1;
              fb_addr  <= addr;
              fb_wdata <= bus.req_data;
            end
            if (col_inc_ok) col <= col + 8'd1;
          end else if (bus.req_write) begin
            if (cls.col_lo) begin col[3:0] <= arg[3:0]; dummy_pend <= 1'b1; end
            if (cls.col_hi) begin col[7:4] <= arg[3:0]; dummy_pend <= 1'b1; end
            if (cls.page)   begin page <= arg[3:0];     dummy_pend <= 1'b1; end
            if (cls.start)  start_line <= arg;
            if (cls.disp)   disp_on    <= arg[0];
            if (cls.rev)    disp_rev   <= arg[0];
            if (cls.adc)    adc_rev    <= arg[0];
            if (cls.sreset) begin
              page       <= '0;
              col        <= '0;
              start_line <= '0;
              dummy_pend <= 1'b1;
`ifdef LCD_RMW_EN
              rmw        <= 1'b0;
`endif
            end
`ifdef LCD_RMW_EN
            if (cls.rmw)  begin rmw <= 1'b1; saved_col <= col; end
            if (cls.rend) begin rmw <= 1'b0; col <= saved_col; end
`endif
          end else begin
            // Counter side effects are committed at acceptance; the response follows later.
            state     <= RD_ADDR;
            fb_addr   <= addr;
            rd_status <= !bus.req_dc;
            rd_dummy  <= bus.req_dc && dummy_pend;
            rd_ff     <= !pos_ok;
            if (bus.req_dc) begin
              if (dummy_pend)                 dummy_pend <= 1'b0;
              else if (!rmw_on && col_inc_ok) col        <= col + 8'd1;
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b1;
          if (rd_status)      bus.rsp_data <= {1'b0, adc_rev, ~disp_on, 5'b0};
          else if (!rd_dummy) bus.rsp_data <= rd_ff ? 8'hFF : fb_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
